// File: rtl/rv32im_pipe_pkg.sv
// rtl/rv32im_pipe_pkg.sv - shared pipeline-stage types, default widths and control reset value
package rv32im_pipe_pkg;

    // Occupancy of a stage when the skid slot is built in
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CTRL_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 16;

    // Control bits are all-zero when a slot is empty so a bubble never writes anything
    localparam logic CTRL_RST_BIT = 1'b0;

endpackage

// File: rtl/pr_stage_slot.sv
// rtl/pr_stage_slot.sv - one ctrl+data holding register with load enable and ctrl clear
module pr_stage_slot
    import rv32im_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  LOAD,
    input  logic                  CLEAR,
    input  logic [CTRL_WIDTH-1:0] IN_CTRL,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic [CTRL_WIDTH-1:0] OUT_CTRL,
    output logic [DATA_WIDTH-1:0] OUT_DATA
);

    // Clear wins over load for ctrl; payload only changes on a real load and survives a clear
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OUT_CTRL <= {CTRL_WIDTH{CTRL_RST_BIT}};
            OUT_DATA <= '0;
        end else begin
            if (CLEAR) begin
                OUT_CTRL <= {CTRL_WIDTH{CTRL_RST_BIT}};
            end else if (LOAD) begin
                OUT_CTRL <= IN_CTRL;
            end
            if (LOAD && !CLEAR) begin
                OUT_DATA <= IN_DATA;
            end
        end
    end

endmodule

// File: rtl/pr_stage_hs.sv
// rtl/pr_stage_hs.sv - handshaked pipeline stage register with flush and stall counter; skid slot when PR_SKID_BUFFER_EN is defined
module pr_stage_hs
    import rv32im_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [CTRL_WIDTH-1:0] IN_CTRL,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [CTRL_WIDTH-1:0] OUT_CTRL,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    input  logic                  FLUSH,
    output logic [CNT_WIDTH-1:0]  STALL_COUNT
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                  accept;
    logic                  rel;
    logic                  main_load;
    logic                  main_clear;
    logic [CTRL_WIDTH-1:0] main_ctrl_d;
    logic [DATA_WIDTH-1:0] main_data_d;

    assign accept = IN_VALID & IN_READY;
    assign rel    = OUT_VALID & OUT_READY;

`ifdef PR_SKID_BUFFER_EN
    stage_state_t          state;
    logic                  skid_load;
    logic                  skid_clear;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;

    // Ready comes straight from the state register, so OUT_READY never reaches IN_READY
    assign IN_READY  = RESET_N & (state != ST_FULL);
    assign OUT_VALID = (state != ST_EMPTY);

    assign main_load   = ~FLUSH & (((state == ST_EMPTY) & accept) |
                                   ((state == ST_BUSY) & accept & rel) |
                                   ((state == ST_FULL) & rel));
    assign main_clear  = FLUSH | ((state == ST_BUSY) & rel & ~accept);
    assign main_ctrl_d = (state == ST_FULL) ? skid_ctrl : IN_CTRL;
    assign main_data_d = (state == ST_FULL) ? skid_data : IN_DATA;
    assign skid_load   = ~FLUSH & (state == ST_BUSY) & accept & ~rel;
    assign skid_clear  = FLUSH | ((state == ST_FULL) & rel);

    // Occupancy FSM: flush empties both slots, otherwise track accepts against releases
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_EMPTY;
        end else if (FLUSH) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state <= ST_BUSY;
                ST_BUSY: begin
                    if (accept && !rel) state <= ST_FULL;
                    else if (rel && !accept) state <= ST_EMPTY;
                end
                ST_FULL:  if (rel) state <= ST_BUSY;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    pr_stage_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_skid (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .LOAD     (skid_load),
        .CLEAR    (skid_clear),
        .IN_CTRL  (IN_CTRL),
        .IN_DATA  (IN_DATA),
        .OUT_CTRL (skid_ctrl),
        .OUT_DATA (skid_data)
    );
`else
    logic out_valid_q;

    assign IN_READY  = RESET_N & (~out_valid_q | OUT_READY);
    assign OUT_VALID = out_valid_q;

    assign main_load   = accept & ~FLUSH;
    assign main_clear  = FLUSH | (rel & ~accept);
    assign main_ctrl_d = IN_CTRL;
    assign main_data_d = IN_DATA;

    // Single-slot valid bit: flush squashes, accept fills, a bare release drains
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid_q <= 1'b0;
        end else if (FLUSH) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
        end else if (rel) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    pr_stage_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_main (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .LOAD     (main_load),
        .CLEAR    (main_clear),
        .IN_CTRL  (main_ctrl_d),
        .IN_DATA  (main_data_d),
        .OUT_CTRL (OUT_CTRL),
        .OUT_DATA (OUT_DATA)
    );

    // Saturating count of cycles the downstream held back a valid entry (flush cycles excluded)
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            STALL_COUNT <= '0;
        end else if (OUT_VALID && !OUT_READY && !FLUSH && (STALL_COUNT != CNT_MAX)) begin
            STALL_COUNT <= STALL_COUNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_pr_stage_hs.sv
// tb/tb_pr_stage_hs.sv - scoreboard bench for pr_stage_hs (4-bit stall counter instance)
module tb_pr_stage_hs;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [15:0] IN_CTRL = '0;
    logic [31:0] IN_DATA = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [15:0] OUT_CTRL;
    logic [31:0] OUT_DATA;
    logic        FLUSH = 1'b0;
    logic [3:0]  STALL_COUNT;

    typedef struct {
        logic [15:0] c;
        logic [31:0] d;
        int          cyc;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   chk_lat = 0;

    pr_stage_hs #(
        .DATA_WIDTH (32),
        .CTRL_WIDTH (16),
        .CNT_WIDTH  (4)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_CTRL     (IN_CTRL),
        .IN_DATA     (IN_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_CTRL    (OUT_CTRL),
        .OUT_DATA    (OUT_DATA),
        .FLUSH       (FLUSH),
        .STALL_COUNT (STALL_COUNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every release, and watch the bubble invariant
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (!OUT_VALID) chk("bubble_ctrl_zero", {48'd0, OUT_CTRL}, 64'd0);
            if (OUT_VALID && OUT_READY) begin
                if (q.size() == 0) begin
                    chk("unexpected_entry", {32'd0, OUT_DATA}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    ent_t e;
                    e = q.pop_front();
                    chk("out_data", {32'd0, OUT_DATA}, {32'd0, e.d});
                    chk("out_ctrl", {48'd0, OUT_CTRL}, {48'd0, e.c});
                    if (chk_lat) chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Present one entry until accepted; push the expectation if it should emerge
    task automatic send(input logic [15:0] c, input logic [31:0] d, input bit expect_out);
        bit   ok;
        ent_t e;
        ok = 0;
        IN_VALID = 1'b1;
        IN_CTRL  = c;
        IN_DATA  = d;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge CLK);
            if (IN_READY) ok = 1;
            @(posedge CLK);
        end
        #1;
        IN_VALID = 1'b0;
        if (!ok) begin
            chk("send_timeout", 64'd0, 64'd1);
        end else if (expect_out) begin
            e.c = c;
            e.d = d;
            e.cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge CLK);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 RESET_N = 1'b0;
        @(negedge CLK);
        chk("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
        chk("rst_out_ctrl", {48'd0, OUT_CTRL}, 64'd0);
        chk("rst_out_data", {32'd0, OUT_DATA}, 64'd0);
        chk("rst_stall_cnt", {60'd0, STALL_COUNT}, 64'd0);
        chk("rst_in_ready", {63'd0, IN_READY}, 64'd0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_in_ready", {63'd0, IN_READY}, 64'd1);
        @(posedge CLK); #1;

        // Stream of 8 at full rate, one-cycle latency
        OUT_READY = 1'b1;
        chk_lat = 1;
        for (int i = 0; i < 8; i++) send(16'h0010 + 16'(i), 32'h100 + 32'(i), 1);
        drain();
        chk_lat = 0;
        chk("stream_stall_cnt", {60'd0, STALL_COUNT}, 64'd0);
        idle(1);

        // Five-cycle stall holds the entry bit-exact, then exactly one release
        OUT_READY = 1'b0;
        send(16'h00FF, 32'hDEAD_BEEF, 1);
        repeat (5) begin
            @(negedge CLK);
            chk("stall_valid", {63'd0, OUT_VALID}, 64'd1);
            chk("stall_ctrl", {48'd0, OUT_CTRL}, 64'h00FF);
            chk("stall_data", {32'd0, OUT_DATA}, 64'hDEAD_BEEF);
            @(posedge CLK);
        end
        #1 OUT_READY = 1'b1;
        @(negedge CLK);
        chk("stall_cnt_5", {60'd0, STALL_COUNT}, 64'd5);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("after_release_valid", {63'd0, OUT_VALID}, 64'd0);
        chk("after_release_ctrl", {48'd0, OUT_CTRL}, 64'd0);
        drain();
        @(posedge CLK); #1;

        // Flush squashes the held entry and the entry offered in the flush cycle
        OUT_READY = 1'b0;
        send(16'h0A0A, 32'h0000_1111, 0);
        IN_VALID = 1'b1;
        IN_CTRL  = 16'h0B0B;
        IN_DATA  = 32'h0000_2222;
        FLUSH    = 1'b1;
        @(posedge CLK); #1;
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("flush_valid", {63'd0, OUT_VALID}, 64'd0);
        chk("flush_ctrl", {48'd0, OUT_CTRL}, 64'd0);
        chk("flush_data_kept", {32'd0, OUT_DATA}, 64'h0000_1111);
        chk("flush_in_ready", {63'd0, IN_READY}, 64'd1);
        chk("flush_stall_cnt", {60'd0, STALL_COUNT}, 64'd5);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        idle(5);

        // Back-pressure: stage fills to its capacity, then drains in order
        OUT_READY = 1'b0;
        send(16'h0001, 32'hA000_0001, 1);
`ifdef PR_SKID_BUFFER_EN
        send(16'h0002, 32'hA000_0002, 1);
`endif
        IN_VALID = 1'b1;
        IN_CTRL  = 16'h0003;
        IN_DATA  = 32'hA000_0003;
        repeat (3) begin
            @(negedge CLK);
            chk("bp_in_ready", {63'd0, IN_READY}, 64'd0);
            chk("bp_head_data", {32'd0, OUT_DATA}, 64'hA000_0001);
            @(posedge CLK);
        end
        #1 OUT_READY = 1'b1;
        send(16'h0003, 32'hA000_0003, 1);
        drain();
        idle(1);

        // Asynchronous reset between edges while stalled
        OUT_READY = 1'b0;
        send(16'h0C0C, 32'h0000_3333, 0);
        idle(2);
        #2 RESET_N = 1'b0;
        #1;
        chk("amid_rst_valid", {63'd0, OUT_VALID}, 64'd0);
        chk("amid_rst_ctrl", {48'd0, OUT_CTRL}, 64'd0);
        chk("amid_rst_data", {32'd0, OUT_DATA}, 64'd0);
        chk("amid_rst_cnt", {60'd0, STALL_COUNT}, 64'd0);
        chk("amid_rst_in_ready", {63'd0, IN_READY}, 64'd0);
        #1 RESET_N = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        idle(5);

        // Saturation of the 4-bit stall counter
        OUT_READY = 1'b0;
        send(16'h0D0D, 32'h0000_4444, 1);
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        chk("stall_cnt_sat", {60'd0, STALL_COUNT}, 64'd15);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        drain();
        idle(2);

        chk("final_queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
